// File: rtl/rtc_pkg.sv
// Shared RTC bus definitions: FSM state encoding, default processor port ids
// and per-state bus drive levels. The processor-side input mux imports it too.
package rtc_pkg;

   localparam int unsigned DATA_W = 8;

   localparam logic [DATA_W-1:0] PORT_ADDR   = 8'h01;
   localparam logic [DATA_W-1:0] PORT_WDATA  = 8'h02;
   localparam logic [DATA_W-1:0] PORT_RSTART = 8'h03;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_A_PH  = 3'd1,
      ST_A_GAP = 3'd2,
      ST_D_PH  = 3'd3,
      ST_D_GAP = 3'd4
   } rtc_state_e;

   typedef struct packed {
      logic              ad;
      logic              cs;
      logic              rd;
      logic              wr;
      logic              oe;
      logic [DATA_W-1:0] data;
   } rtc_bus_t;

   localparam rtc_bus_t BUS_IDLE = '{ad: 1'b1, cs: 1'b1, rd: 1'b1, wr: 1'b1,
                                     oe: 1'b0, data: '0};

   // Bus levels held for the whole of a state; IDLE and D_GAP release the bus.
   function automatic rtc_bus_t bus_drive(rtc_state_e st, logic is_read,
                                          logic [DATA_W-1:0] addr,
                                          logic [DATA_W-1:0] wdata);
      rtc_bus_t b;
      b = BUS_IDLE;
      case (st)
         ST_A_PH: begin
            b.ad   = 1'b0;
            b.cs   = 1'b0;
            b.wr   = 1'b0;
            b.oe   = 1'b1;
            b.data = addr;
         end
         ST_A_GAP: begin
            b.ad   = 1'b0;
            b.oe   = 1'b1;
            b.data = addr;
         end
         ST_D_PH: begin
            b.cs = 1'b0;
            if (is_read) begin
               b.rd = 1'b0;
            end else begin
               b.wr   = 1'b0;
               b.oe   = 1'b1;
               b.data = wdata;
            end
         end
         default: ;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Per-phase clock counter: clears on load, counts while enabled, flags the last clock.
module rtc_phase_timer #(
   parameter int unsigned T_PHASE = 10
) (
   input  logic clock,
   input  logic reset,
   input  logic load,
   input  logic count,
   output logic tc_c
);

   localparam int unsigned CNT_W = 8;

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= '0;
      end else if (count) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign tc_c = count && (cnt == CNT_W'(T_PHASE - 1));

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Sequences multiplexed-bus RTC read/write cycles (address phase, gap, data phase, gap)
// from processor port writes, and reports completion and read data back as ports.
module rtc_bus_sequencer
   import rtc_pkg::*;
#(
   parameter int unsigned       T_PHASE  = 10,
   parameter logic [DATA_W-1:0] P_ADDR   = PORT_ADDR,
   parameter logic [DATA_W-1:0] P_WDATA  = PORT_WDATA,
   parameter logic [DATA_W-1:0] P_RSTART = PORT_RSTART
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] port_id,
   input  logic [DATA_W-1:0] out_port,
   input  logic              write_strobe,
   input  logic [DATA_W-1:0] ad_in,
   output logic [DATA_W-1:0] ad_out,
   output logic              ad_oe,
   output logic              AD,
   output logic              CS,
   output logic              RD,
   output logic              WR,
   output logic [DATA_W-1:0] datao_rtc_port,
   output logic [DATA_W-1:0] donew_port,
   output logic [DATA_W-1:0] doner_port
);

   rtc_state_e        state, state_nx;
   rtc_bus_t          bus_q, bus_nx;
   logic              start_q;
   logic              is_read;
   logic [DATA_W-1:0] addr_reg, wdata_reg, cyc_addr;
   logic              tc_c;
   logic              idle_free_c, hit_addr_c, accept_w_c, accept_r_c;

   // A command is only taken when fully idle: no cycle running and none pending.
   assign idle_free_c = (state == ST_IDLE) && !start_q;
   assign hit_addr_c  = write_strobe && (port_id == P_ADDR);
   assign accept_w_c  = write_strobe && (port_id == P_WDATA)  && idle_free_c;
   assign accept_r_c  = write_strobe && (port_id == P_RSTART) && idle_free_c;

   rtc_phase_timer #(.T_PHASE(T_PHASE)) u_timer (
      .clock (clock),
      .reset (reset),
      .load  (state_nx != state),
      .count (state != ST_IDLE),
      .tc_c  (tc_c)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      bus_nx   = BUS_IDLE;
      case (state)
         ST_IDLE:  if (start_q) state_nx = ST_A_PH;
         ST_A_PH:  if (tc_c)    state_nx = ST_A_GAP;
         ST_A_GAP: if (tc_c)    state_nx = ST_D_PH;
         ST_D_PH:  if (tc_c)    state_nx = ST_D_GAP;
         ST_D_GAP: if (tc_c)    state_nx = ST_IDLE;
         default:               state_nx = ST_IDLE;
      endcase
      bus_nx = bus_drive(state_nx, is_read, cyc_addr, wdata_reg);
   end

   // Command latches, read capture and done flags; bus levels are registered from next state.
   always_ff @(posedge clock) begin
      if (reset) begin
         start_q        <= 1'b0;
         is_read        <= 1'b0;
         addr_reg       <= '0;
         wdata_reg      <= '0;
         cyc_addr       <= '0;
         datao_rtc_port <= '0;
         donew_port     <= '0;
         doner_port     <= '0;
         bus_q          <= BUS_IDLE;
      end else begin
         bus_q <= bus_nx;
         if (hit_addr_c) begin
            addr_reg <= out_port;
         end
         if (state == ST_IDLE && start_q) begin
            start_q <= 1'b0;
         end
         if (accept_w_c) begin
            wdata_reg  <= out_port;
            cyc_addr   <= addr_reg;
            is_read    <= 1'b0;
            donew_port <= '0;
            start_q    <= 1'b1;
         end
         if (accept_r_c) begin
            cyc_addr   <= addr_reg;
            is_read    <= 1'b1;
            doner_port <= '0;
            start_q    <= 1'b1;
         end
         if (state == ST_D_PH && tc_c && is_read) begin
            datao_rtc_port <= ad_in;
         end
         if (state == ST_D_GAP && tc_c) begin
            if (is_read) begin
               doner_port <= DATA_W'(1);
            end else begin
               donew_port <= DATA_W'(1);
            end
         end
      end
   end

   assign ad_out = bus_q.data;
   assign ad_oe  = bus_q.oe;
   assign AD     = bus_q.ad;
   assign CS     = bus_q.cs;
   assign RD     = bus_q.rd;
   assign WR     = bus_q.wr;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Self-checking bench for rtc_bus_sequencer: directed scenarios plus randomized cycles
// compared against a phase-arithmetic reference model.
module tb_rtc_bus_sequencer;

   localparam int T = 4;
   localparam logic [7:0] ID_ADDR   = 8'h01;
   localparam logic [7:0] ID_WDATA  = 8'h02;
   localparam logic [7:0] ID_RSTART = 8'h03;
   localparam logic [12:0] IDLE_VEC = 13'h1E00;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] port_id = 8'h00;
   logic [7:0] out_port = 8'h00;
   logic       write_strobe = 1'b0;
   logic [7:0] ad_in = 8'h00;
   logic [7:0] ad_out;
   logic       ad_oe, AD, CS, RD, WR;
   logic [7:0] datao_rtc_port, donew_port, doner_port;

   logic [7:0] m_addr, m_donew, m_doner, m_datao;
   int         n_checks = 0;
   int         n_pass = 0;

   always #5 clock = ~clock;

   rtc_bus_sequencer #(.T_PHASE(T)) dut (
      .clock          (clock),
      .reset          (reset),
      .port_id        (port_id),
      .out_port       (out_port),
      .write_strobe   (write_strobe),
      .ad_in          (ad_in),
      .ad_out         (ad_out),
      .ad_oe          (ad_oe),
      .AD             (AD),
      .CS             (CS),
      .RD             (RD),
      .WR             (WR),
      .datao_rtc_port (datao_rtc_port),
      .donew_port     (donew_port),
      .doner_port     (doner_port)
   );

   // Expected {AD,CS,RD,WR,oe,data} n clocks after the command edge; each phase spans T clocks.
   function automatic logic [12:0] exp_bus(int n, bit rd, logic [7:0] a, logic [7:0] w);
      int ph;
      ph = (n < 1 || n > 4*T) ? 4 : (n - 1) / T;
      case (ph)
         0: return {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, a};
         1: return {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, a};
         2: return rd ? {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00}
                      : {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, w};
         3: return IDLE_VEC;
         default: return IDLE_VEC;
      endcase
   endfunction

   // AD is unconstrained in the address gap; bus data is irrelevant whenever ad_oe=0 mid-cycle.
   function automatic logic [12:0] bus_mask(int n, bit rd);
      int ph;
      ph = (n < 1 || n > 4*T) ? 4 : (n - 1) / T;
      if (ph == 1) return 13'h0FFF;
      if ((ph == 2 && rd) || ph == 3) return 13'h1F00;
      return 13'h1FFF;
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic send(input logic [7:0] id, input logic [7:0] d);
      port_id      = id;
      out_port     = d;
      write_strobe = 1'b1;
      step();
      write_strobe = 1'b0;
      port_id      = 8'h00;
      out_port     = 8'h00;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
      m_addr = 8'h00; m_donew = 8'h00; m_doner = 8'h00; m_datao = 8'h00;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) step();
      n_checks++;
      if ({AD, CS, RD, WR, ad_oe, ad_out} !== IDLE_VEC)
         $display("FAIL reset_bus: got %h, expected %h", {AD, CS, RD, WR, ad_oe, ad_out}, IDLE_VEC);
      else n_pass++;
      n_checks++;
      if ({donew_port, doner_port, datao_rtc_port} !== 24'h0)
         $display("FAIL reset_flags: got %h, expected 000000", {donew_port, doner_port, datao_rtc_port});
      else n_pass++;
      reset = 1'b0;
      step();
      n_checks++;
      if ({AD, CS, RD, WR, ad_oe, ad_out} !== IDLE_VEC)
         $display("FAIL post_reset_bus: got %h, expected %h", {AD, CS, RD, WR, ad_oe, ad_out}, IDLE_VEC);
      else n_pass++;
      m_addr = 8'h00; m_donew = 8'h00; m_doner = 8'h00; m_datao = 8'h00;
   endtask

   // One full bus cycle, checked every clock; optionally one extra strobe at position inj_n.
   task automatic test_bus_cycle(input string name, input bit rd, input bit set_addr,
                                 input logic [7:0] addr, input logic [7:0] wd,
                                 input logic [7:0] rdval, input int inj_n,
                                 input logic [7:0] inj_id, input logic [7:0] inj_data);
      logic [7:0]  cyc_addr, e_w, e_r, e_d;
      logic [12:0] got, exp, msk;
      e_w = m_donew; e_r = m_doner; e_d = m_datao;
      if (set_addr) begin
         send(ID_ADDR, addr);
         m_addr = addr;
      end
      cyc_addr = m_addr;
      ad_in    = ~rdval;
      if (rd) send(ID_RSTART, 8'h00);
      else    send(ID_WDATA, wd);
      for (int n = 0; n <= 4*T + 1; n++) begin
         if (n > 0) begin
            step();
            write_strobe = 1'b0;
            port_id      = 8'h00;
            out_port     = 8'h00;
         end
         got = {AD, CS, RD, WR, ad_oe, ad_out};
         exp = exp_bus(n, rd, cyc_addr, wd);
         msk = bus_mask(n, rd);
         n_checks++;
         if ((got & msk) !== (exp & msk))
            $display("FAIL %s bus n=%0d: got %h, expected %h (mask %h)", name, n, got, exp, msk);
         else n_pass++;
         e_w = m_donew; e_r = m_doner; e_d = m_datao;
         if (rd) begin
            e_r = (n > 4*T) ? 8'h01 : 8'h00;
            if (n > 3*T) e_d = rdval;
         end else begin
            e_w = (n > 4*T) ? 8'h01 : 8'h00;
         end
         n_checks++;
         if ({donew_port, doner_port, datao_rtc_port} !== {e_w, e_r, e_d})
            $display("FAIL %s flags n=%0d: got %h, expected %h", name, n,
                     {donew_port, doner_port, datao_rtc_port}, {e_w, e_r, e_d});
         else n_pass++;
         if (n == inj_n && inj_id != 8'h00) begin
            port_id      = inj_id;
            out_port     = inj_data;
            write_strobe = 1'b1;
            if (inj_id == ID_ADDR) m_addr = inj_data;
         end
         ad_in = (rd && n >= 2*T + 1 && n <= 3*T) ? rdval : ~rdval;
      end
      m_donew = e_w; m_doner = e_r; m_datao = e_d;
   endtask

   task automatic test_ignore_cmd();
      do_reset();
      test_bus_cycle("ignore_wdata", 1'b1, 1'b1, 8'h22, 8'h00, 8'h4C, 2*T + 2, ID_WDATA, 8'hAA);
      n_checks++;
      if (donew_port !== 8'h00)
         $display("FAIL ignore_wdata_donew: got %h, expected 00", donew_port);
      else n_pass++;
   endtask

   task automatic test_addr_update();
      test_bus_cycle("addr_gap", 1'b0, 1'b1, 8'h21, 8'h33, 8'h00, T + 2, ID_ADDR, 8'h10);
      test_bus_cycle("addr_next", 1'b0, 1'b0, 8'h00, 8'h44, 8'h00, 0, 8'h00, 8'h00);
   endtask

   task automatic test_bad_port();
      send(8'h0b, 8'h5A);
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if ({AD, CS, RD, WR, ad_oe, ad_out} !== IDLE_VEC)
            $display("FAIL bad_port_bus i=%0d: got %h, expected %h", i, {AD, CS, RD, WR, ad_oe, ad_out}, IDLE_VEC);
         else n_pass++;
         n_checks++;
         if ({donew_port, doner_port, datao_rtc_port} !== {m_donew, m_doner, m_datao})
            $display("FAIL bad_port_flags i=%0d: got %h, expected %h", i,
                     {donew_port, doner_port, datao_rtc_port}, {m_donew, m_doner, m_datao});
         else n_pass++;
         step();
      end
      test_bus_cycle("bad_port_mid", 1'b1, 1'b0, 8'h00, 8'h00, 8'h9E, 3, 8'h0b, 8'h77);
   endtask

   task automatic test_reset_mid();
      send(ID_ADDR, 8'h21);
      send(ID_WDATA, 8'h59);
      repeat (2*T + 2) step();
      reset = 1'b1;
      step();
      n_checks++;
      if ({CS, WR, ad_oe} !== 3'b110)
         $display("FAIL reset_mid_strobes: got %b, expected 110", {CS, WR, ad_oe});
      else n_pass++;
      n_checks++;
      if ({donew_port, doner_port, datao_rtc_port} !== 24'h0)
         $display("FAIL reset_mid_flags: got %h, expected 000000", {donew_port, doner_port, datao_rtc_port});
      else n_pass++;
      reset = 1'b0;
      m_addr = 8'h00; m_donew = 8'h00; m_doner = 8'h00; m_datao = 8'h00;
      repeat (4*T) step();
      n_checks++;
      if ({AD, CS, RD, WR, ad_oe, ad_out, donew_port} !== {IDLE_VEC, 8'h00})
         $display("FAIL reset_mid_after: got %h, expected %h",
                  {AD, CS, RD, WR, ad_oe, ad_out, donew_port}, {IDLE_VEC, 8'h00});
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      test_bus_cycle("b2b_first", 1'b1, 1'b1, 8'h05, 8'h00, 8'h61, 4*T, ID_RSTART, 8'h00);
      test_bus_cycle("b2b_second", 1'b0, 1'b0, 8'h00, 8'hC3, 8'h00, 0, 8'h00, 8'h00);
   endtask

   task automatic test_random();
      logic [7:0] inj_id;
      for (int k = 0; k < 16; k++) begin
         case ($urandom_range(0, 4))
            0: inj_id = ID_ADDR;
            1: inj_id = ID_WDATA;
            2: inj_id = ID_RSTART;
            3: inj_id = 8'h0b;
            default: inj_id = 8'h00;
         endcase
         test_bus_cycle("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        8'($urandom), 8'($urandom), 8'($urandom),
                        int'($urandom_range(1, 4*T)), inj_id, 8'($urandom));
      end
   endtask

   initial begin
      test_reset();
      test_bus_cycle("write", 1'b0, 1'b1, 8'h21, 8'h59, 8'h00, 0, 8'h00, 8'h00);
      test_bus_cycle("read", 1'b1, 1'b1, 8'h22, 8'h00, 8'h37, 0, 8'h00, 8'h00);
      test_ignore_cmd();
      test_addr_update();
      test_bad_port();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/rtc_bus_sequencer.md
RTC_BUS_SEQUENCER -- requirements
Module: rtc_bus_sequencer

Interface
REQ-001 SHALL have parameter T_PHASE, default 10, clocks per bus phase (range 2..255).
REQ-002 SHALL have parameter P_ADDR, default 8'h01, port_id that loads the RTC register address.
REQ-003 SHALL have parameter P_WDATA, default 8'h02, port_id that loads write data and starts a write cycle.
REQ-004 SHALL have parameter P_RSTART, default 8'h03, port_id that starts a read cycle.
REQ-005 SHALL have port: clock  input  1  single system clock; all logic on its rising edge.
REQ-006 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port: port_id  input  8  processor port address.
REQ-008 SHALL have port: out_port  input  8  processor output data.
REQ-009 SHALL have port: write_strobe  input  1  one-cycle qualifier for out_port/port_id.
REQ-010 SHALL have port: ad_in  input  8  data sampled from the RTC multiplexed bus.
REQ-011 SHALL have port: ad_out  output  8  value driven onto the RTC bus.
REQ-012 SHALL have port: ad_oe  output  1  high = FPGA drives bus (tristate buffer lives at top level).
REQ-013 SHALL have port: AD  output  1  address/data select: 0 = address phase, 1 = data phase.
REQ-014 SHALL have port: CS, RD, WR  output  1 each  active-low RTC strobes.
REQ-015 SHALL have port: datao_rtc_port  output  8  last byte read from the RTC.
REQ-016 SHALL have port: donew_port  output  8  8'h01 once a write cycle completes, else 8'h00.
REQ-017 SHALL have port: doner_port  output  8  8'h01 once a read cycle completes, else 8'h00.

Function
REQ-018 SHALL decode a command only when write_strobe=1 and port_id matches a P_* parameter exactly; unmatched ids are ignored.
REQ-019 SHALL load addr_reg from out_port on P_ADDR in any state; the running cycle keeps its latched address.
REQ-020 SHALL, on P_WDATA in IDLE, latch out_port into wdata_reg, clear donew_port, and enter W_ADDR on the next clock.
REQ-021 SHALL, on P_RSTART in IDLE, clear doner_port and enter W_ADDR (read variant) on the next clock.
REQ-022 SHALL ignore P_WDATA/P_RSTART when not in IDLE (no queueing, done flags untouched).
REQ-023 FSM states, each held exactly T_PHASE clocks: IDLE, A_PH (AD=0, CS=0, WR=0, ad_oe=1, ad_out=addr), A_GAP (CS=1, WR=1, ad_oe=1, ad_out=addr), D_PH, D_GAP, then IDLE.
REQ-024 Write D_PH: AD=1, CS=0, WR=0, RD=1, ad_oe=1, ad_out=wdata_reg.
REQ-025 Read D_PH: AD=1, CS=0, RD=0, WR=1, ad_oe=0; ad_in SHALL be captured into datao_rtc_port on the last D_PH clock.
REQ-026 D_GAP: AD=1, CS=RD=WR=1, ad_oe=0; on its last clock the relevant done flag SHALL be set to 8'h01, visible the cycle IDLE is re-entered.
REQ-027 Command-to-IDLE latency SHALL be exactly 4*T_PHASE+1 clocks.
REQ-028 Phase counter SHALL count 0..T_PHASE-1 and reset to 0 at every state change; no wrap mid-phase.
REQ-029 Simultaneous P_RSTART and P_WDATA is impossible (one port_id per strobe); a strobe in the same clock as return to IDLE SHALL be ignored.
REQ-030 All outputs SHALL be registered; no strobe glitches between phases.
REQ-031 In IDLE: AD=1, CS=RD=WR=1, ad_oe=0, ad_out=8'h00.

Reset
REQ-032 Reset SHALL force IDLE, counter=0, addr_reg=wdata_reg=8'h00, datao_rtc_port=8'h00, donew_port=doner_port=8'h00, IDLE output levels.
REQ-033 Reset mid-cycle SHALL abort on the next clock with CS/RD/WR high and ad_oe=0; no done flag set.

Structure
REQ-034 State encoding and default P_* port ids SHALL live in shared package rtc_pkg, reused by the processor-side input mux.
REQ-035 A single sub-module rtc_phase_timer (load, count, terminal-count pulse) SHALL be used; remaining logic is flat.

Verification
REQ-036 T_PHASE=4: write 8'h21 to P_ADDR, 8'h59 to P_WDATA -> A_PH bus 8'h21 for 4 clocks, D_PH bus 8'h59 with WR=0 for 4 clocks, donew_port=8'h01 at clock 17.
REQ-037 Address 8'h22, P_RSTART, ad_in=8'h37 during D_PH -> RD=0 for 4 clocks, ad_oe=0, datao_rtc_port=8'h37, doner_port=8'h01.
REQ-038 P_WDATA 8'hAA during a read cycle -> ignored; read completes, donew_port stays 8'h00, wdata unchanged.
REQ-039 Reset asserted in D_PH of a write -> next clock CS=WR=1, ad_oe=0, all flags 8'h00, datao_rtc_port=8'h00.
REQ-040 P_ADDR 8'h10 written during A_GAP of an 8'h21 cycle -> bus still shows 8'h21; next cycle uses 8'h10.
REQ-041 Strobe with port_id 8'h0b -> no state change, outputs unchanged.
